// File: rtl/seq_pkg.sv
// Shared opcodes, unit indices, error codes and FSM states for the script sequencer.
// The watchdog is only present when SEQ_WATCHDOG_EN is defined.
package seq_pkg;

    localparam logic [2:0] OP_ACTION = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_WAIT   = 3'b011;
    localparam logic [2:0] OP_GAME   = 3'b100;
    localparam logic [2:0] OP_END    = 3'b111;

    localparam int UNIT_ACTION = 0;
    localparam int UNIT_JUMP   = 1;
    localparam int UNIT_WAIT   = 2;
    localparam int UNIT_GAME   = 3;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_WDOG    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_EXEC,
        S_HALT,
        S_ERROR
    } state_t;

    // Maps a unit opcode to its one-hot dispatch bit; anything else gives zero.
    function automatic logic [3:0] unit_onehot(input logic [2:0] op);
        logic [3:0] sel;
        sel = 4'b0000;
        case (op)
            OP_ACTION: sel[UNIT_ACTION] = 1'b1;
            OP_JUMP:   sel[UNIT_JUMP]   = 1'b1;
            OP_WAIT:   sel[UNIT_WAIT]   = 1'b1;
            OP_GAME:   sel[UNIT_GAME]   = 1'b1;
            default:   sel = 4'b0000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/script_sequencer_if.sv
// Dispatch bus between the script sequencer (master) and its execution units (slave).
interface script_sequencer_if;

    logic [15:0] instr_q;
    logic [3:0]  op_valid;
    logic [3:0]  unit_done;
    logic        jump_taken;
    logic [7:0]  jump_target;

    modport master (
        output instr_q,
        output op_valid,
        input  unit_done,
        input  jump_taken,
        input  jump_target
    );

    modport slave (
        input  instr_q,
        input  op_valid,
        output unit_done,
        output jump_taken,
        output jump_target
    );

endinterface

// File: rtl/seq_watchdog.sv
// Per-instruction EXEC cycle counter; flags expiry on the LIMIT-th EXEC cycle.
module seq_watchdog #(
    parameter logic [31:0] LIMIT = 32'd500_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    output logic expired
);

    logic [31:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 32'd0;
        end else if (clear) begin
            count <= 32'd0;
        end else if (active) begin
            count <= count + 32'd1;
        end
    end

    assign expired = active && (count == LIMIT - 32'd1);

endmodule

// File: rtl/script_sequencer.sv
// Fetch/decode/dispatch sequencer for the traveler script engine.
// Define SEQ_WATCHDOG_EN to compile in the per-instruction EXEC watchdog.
module script_sequencer
    import seq_pkg::*;
#(
    parameter int          PC_STEP     = 2,
    parameter logic [31:0] WDOG_CYCLES = 32'd500_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run_en,
    input  logic                       step,
    output logic [7:0]                 pc,
    input  logic [15:0]                instr,
    script_sequencer_if.master         units,
    output logic                       busy,
    output logic                       halted,
    output logic                       error,
    output logic [1:0]                 err_code
);

    state_t      state;
    logic [15:0] instr_q;
    logic [3:0]  op_valid;
    logic        done_hit;
    logic        wdog_expired;

    assign units.instr_q  = instr_q;
    assign units.op_valid = op_valid;

    // op_valid doubles as the decoded unit select, so only that unit's done counts.
    assign done_hit = (units.unit_done & op_valid) != 4'b0000;

`ifdef SEQ_WATCHDOG_EN
    seq_watchdog #(
        .LIMIT(WDOG_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == S_LATCH),
        .active  (state == S_EXEC),
        .expired (wdog_expired)
    );
`else
    assign wdog_expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= 8'h00;
            instr_q  <= 16'h0000;
            op_valid <= 4'b0000;
            busy     <= 1'b0;
            halted   <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run_en || step) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    instr_q <= instr;
                    case (instr[2:0])
                        OP_ACTION, OP_JUMP, OP_WAIT, OP_GAME: begin
                            op_valid <= unit_onehot(instr[2:0]);
                            state    <= S_EXEC;
                        end
                        OP_END: begin
                            state  <= S_HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end
                        default: begin
                            state    <= S_ERROR;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                            err_code <= ERR_ILLEGAL;
                        end
                    endcase
                end
                S_EXEC: begin
                    if (done_hit) begin
                        op_valid <= 4'b0000;
                        if (op_valid[UNIT_JUMP] && units.jump_taken) begin
                            pc <= units.jump_target & 8'hFE;
                        end else begin
                            pc <= pc + 8'(PC_STEP);
                        end
                        state <= run_en ? S_FETCH : S_IDLE;
                        busy  <= run_en;
                    end else if (wdog_expired) begin
                        op_valid <= 4'b0000;
                        state    <= S_ERROR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_code <= ERR_WDOG;
                    end
                end
                default: begin
                    // HALT and ERROR hold everything until rst.
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: doc/script_sequencer.md
# script_sequencer

Autonomous instruction sequencer for the traveler script engine. It fetches 16-bit script words from the synchronous script memory, decodes the opcode field, and dispatches each instruction to exactly one execution unit (action, jump, wait, game-state) with a valid/done handshake. It updates the program counter from sequential advance or a taken jump, and supports free-run and single-step modes. It sits between the script memory and the execution units and replaces manual button-driven pc stepping.

## Interface
Parameters:
- PC_STEP, 2: pc increment per instruction (byte-addressed 16-bit words).
- WDOG_CYCLES, 32'd500_000_000: watchdog limit in clk cycles for one dispatched instruction (only used with the watchdog compiled in).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- run_en  in  1  level; 1 = free-run, 0 = step mode
- step  in  1  single-cycle pulse, already debounced and synchronised; executes one instruction in step mode
- pc  out  8  script memory address
- instr  in  16  script memory data, valid one cycle after pc changes
- instr_q  out  16  latched current instruction, to the units
- op_valid  out  4  one-hot dispatch: [0] action, [1] jump, [2] wait, [3] game
- unit_done  in  4  per-unit completion pulse or level, same bit order
- jump_taken  in  1  sampled together with unit_done[1]
- jump_target  in  8  sampled together with unit_done[1]
- busy  out  1  high in any state other than IDLE, HALT or ERROR
- halted  out  1  END opcode reached
- error  out  1  sticky fault
- err_code  out  2  01 = illegal opcode, 10 = watchdog timeout, 00 = none

## Operation
- Opcode is instr_q[2:0]: 001 action, 010 jump, 011 wait, 100 game, 111 END. 000, 101 and 110 are illegal.
- States: IDLE, FETCH, LATCH, EXEC, HALT, ERROR.
- IDLE goes to FETCH when run_en=1, or when step=1 while run_en=0.
- FETCH presents pc for one cycle, then goes to LATCH.
- LATCH captures instr into instr_q and decodes it:
  - legal unit opcode: go to EXEC
  - END: go to HALT
  - illegal opcode: go to ERROR with err_code=01
- EXEC drives op_valid with the one-hot bit for the decoded unit, held constant. It leaves EXEC on the first cycle where unit_done for that unit is 1; done bits from other units are ignored. On exit:
  - pc <= jump_target with bit0 forced to 0 if the unit is jump and jump_taken=1, else pc + PC_STEP
  - next state is FETCH if run_en=1, else IDLE
- pc wraps mod 256 (8'hFE + 2 = 8'h00).
- step pulses outside IDLE are ignored, with no queueing.
- run_en deasserted mid-instruction: the current instruction completes, then the sequencer goes to IDLE.
- HALT and ERROR are terminal until rst. In both, op_valid=0 and pc is frozen.
- Reset values: pc=0, instr_q=0, op_valid=0, busy=0, halted=0, error=0, err_code=00, state IDLE. An rst assertion mid-EXEC drops op_valid immediately (asynchronous).

## Timing
- Instruction throughput is 3 cycles minimum (FETCH, LATCH, EXEC) when done arrives in the first EXEC cycle.
- op_valid rises the cycle after LATCH and falls the cycle after the matching done is sampled.
- pc updates on the clock edge that samples the matching done. The next FETCH presents the new pc.
- All outputs are registered. There is no combinational path from unit_done to op_valid.

## Configuration
- SEQ_WATCHDOG_EN defined:
  - A 32-bit counter clears on EXEC entry and increments each EXEC cycle.
  - When it reaches WDOG_CYCLES without the matching done, op_valid drops and the sequencer goes to ERROR with err_code=10.
- SEQ_WATCHDOG_EN undefined: EXEC waits indefinitely, and err_code[1] is constant 0.

## Structure
- seq_pkg holds:
  - opcode constants OP_ACTION, OP_JUMP, OP_WAIT, OP_GAME, OP_END
  - unit index constants
  - state enum
  - err_code constants
- Sub-module seq_watchdog holds the counter and compare, and is instantiated only under SEQ_WATCHDOG_EN.

## Test plan
- run_en=1; memory at 0x00..0x04 holds action, wait, END; done returned 2 cycles after each op_valid rise -> op_valid sequence 0001, 0100; pc 0x00→0x02→0x04; halted=1 with pc frozen at 0x04.
- Jump at 0x06 with jump_taken=1 and jump_target=0x11 -> pc becomes 0x10. Same instruction with jump_taken=0 -> pc becomes 0x08.
- run_en=0; three step pulses, one of them issued during EXEC -> exactly two instructions executed; the pulse issued during EXEC is ignored.
- Opcode 101 at pc 0x0A -> error=1, err_code=01, op_valid=0000, pc stays 0x0A until rst.
- With SEQ_WATCHDOG_EN and WDOG_CYCLES=20, wait unit never signals done -> op_valid falls after 20 EXEC cycles, err_code=10. rst then returns all outputs to reset values.
- pc=0xFE holding an action instruction -> after done, pc=0x00. Done on the wrong unit bit during EXEC -> ignored.
